// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage; owns the PC, issues single outstanding imem
// requests, holds the returned word for the decoder and applies branch/flush redirects.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        n_rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [6:0]  opcode,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        pcsrc,
    input  logic        zero,
    input  logic [31:0] br_imm,
    input  logic        flush,
    input  logic [31:0] flush_pc
);
    typedef enum logic [1:0] {START, REQ, WAIT, HOLD} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d, instr_q, instr_d, ipc_q, ipc_d;
    logic        kill_q, kill_d;

    always_ff @(posedge clk or posedge n_rst) begin
        if (n_rst) begin
            state_q <= START;
            pc_q    <= RESET_PC;
            kill_q  <= 1'b0;
            instr_q <= '0;
            ipc_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            kill_q  <= kill_d;
            instr_q <= instr_d;
            ipc_q   <= ipc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        kill_d  = kill_q;
        instr_d = instr_q;
        ipc_d   = ipc_q;
        case (state_q)
            START: state_d = REQ;
            REQ: begin
                state_d = WAIT;
                kill_d  = flush;
            end
            WAIT: begin
                // the response of a killed request is swallowed and fetch restarts
                if (imem_rvalid) begin
                    kill_d  = 1'b0;
                    state_d = (flush || kill_q) ? REQ : HOLD;
                    if (!flush && !kill_q) begin
                        instr_d = imem_rdata;
                        ipc_d   = pc_q;
                    end
                end else if (flush) begin
                    kill_d = 1'b1;
                end
            end
            HOLD: begin
                if (instr_ready) begin
                    pc_d    = (pcsrc && zero) ? ((ipc_q + br_imm) & 32'hFFFF_FFFC) : ipc_q + 32'd4;
                    state_d = REQ;
                end
                if (flush) state_d = REQ;
            end
            default: state_d = START;
        endcase
        if (flush) pc_d = flush_pc & 32'hFFFF_FFFC;
    end

    assign imem_req    = (state_q == REQ);
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign opcode      = instr_q[6:0];
    assign instr_pc    = ipc_q;
    assign instr_valid = (state_q == HOLD);
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed self-checking bench for fetch_unit with hand-computed expectations.
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        n_rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        pcsrc;
    logic        zero;
    logic [31:0] br_imm;
    logic        flush;
    logic [31:0] flush_pc;

    int n_chk  = 0;
    int n_pass = 0;

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .n_rst(n_rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .instr(instr), .opcode(opcode), .instr_pc(instr_pc), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .pcsrc(pcsrc), .zero(zero), .br_imm(br_imm),
        .flush(flush), .flush_pc(flush_pc)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // Expects the DUT in REQ at address a; returns 1-cycle latency data d and ends in HOLD.
    task automatic fetch(input string tag, input logic [31:0] a, input logic [31:0] d);
        chk({tag, "_req"}, {31'd0, imem_req}, 32'd1);
        chk({tag, "_addr"}, imem_addr, a);
        tick();
        chk({tag, "_wait_req"}, {31'd0, imem_req}, 32'd0);
        chk({tag, "_wait_valid"}, {31'd0, instr_valid}, 32'd0);
        imem_rvalid = 1'b1;
        imem_rdata  = d;
        tick();
        imem_rvalid = 1'b0;
        chk({tag, "_valid"}, {31'd0, instr_valid}, 32'd1);
        chk({tag, "_instr"}, instr, d);
        chk({tag, "_opcode"}, {25'd0, opcode}, {25'd0, d[6:0]});
        chk({tag, "_ipc"}, instr_pc, a);
    endtask

    initial begin
        n_rst = 1'b1; imem_rvalid = 1'b0; imem_rdata = '0; instr_ready = 1'b1;
        pcsrc = 1'b0; zero = 1'b0; br_imm = '0; flush = 1'b0; flush_pc = '0;
        tick(); tick();
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_ipc", instr_pc, 32'd0);
        chk("rst_addr", imem_addr, 32'd0);

        // release: START, then REQ at edge 1, WAIT at edge 2, HOLD at edge 3
        n_rst = 1'b0;
        chk("start_req", {31'd0, imem_req}, 32'd0);
        tick();
        chk("e1_valid", {31'd0, instr_valid}, 32'd0);
        fetch("f0", 32'h0, 32'h0000_0013);
        tick();
        fetch("f4", 32'h4, 32'h0010_0093);
        tick();
        fetch("f8", 32'h8, 32'h0020_0113);
        tick();
        fetch("fc", 32'hC, 32'h0030_0193);
        tick();

        // taken branch: 0x10 + (-8) = 0x08
        fetch("b10", 32'h10, 32'h0000_0063);
        pcsrc = 1'b1; zero = 1'b1; br_imm = 32'hFFFF_FFF8;
        tick();
        chk("br_taken_addr", imem_addr, 32'h08);
        // taken branch back to 0x10 with offset +8
        fetch("b08", 32'h08, 32'h0000_0063);
        br_imm = 32'd8;
        tick();
        chk("br_fwd_addr", imem_addr, 32'h10);
        // not taken: zero = 0 -> 0x14
        fetch("n10", 32'h10, 32'h0000_0063);
        zero = 1'b0; br_imm = 32'hFFFF_FFF8;
        tick();
        chk("br_nt_addr", imem_addr, 32'h14);
        // misaligned target is forced to a word: 0x14 + 7 = 0x1B -> 0x18
        fetch("m14", 32'h14, 32'h0000_0063);
        zero = 1'b1; br_imm = 32'd7;
        tick();
        chk("br_align_addr", imem_addr, 32'h18);
        pcsrc = 1'b0; zero = 1'b0; br_imm = '0;

        // stall 5 cycles in HOLD
        instr_ready = 1'b0;
        fetch("s18", 32'h18, 32'h0050_0093);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_instr", instr, 32'h0050_0093);
            chk("stall_ipc", instr_pc, 32'h18);
            chk("stall_valid", {31'd0, instr_valid}, 32'd1);
            chk("stall_req", {31'd0, imem_req}, 32'd0);
        end
        instr_ready = 1'b1;
        tick();
        chk("stall_next_req", {31'd0, imem_req}, 32'd1);
        chk("stall_next_addr", imem_addr, 32'h1C);

        // flush in WAIT, stale data arrives 2 cycles later and is dropped
        tick();
        flush = 1'b1; flush_pc = 32'h100;
        tick();
        flush = 1'b0;
        chk("fw_addr", imem_addr, 32'h100);
        chk("fw_req", {31'd0, imem_req}, 32'd0);
        tick();
        imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        tick();
        imem_rvalid = 1'b0;
        chk("fw_valid", {31'd0, instr_valid}, 32'd0);
        chk("fw_instr_not_dead", {31'd0, instr == 32'hDEAD_BEEF}, 32'd0);

        // flush and rvalid in the same cycle
        fetch("f100", 32'h100, 32'h0000_0033);
        tick();
        chk("pre_fr_addr", imem_addr, 32'h104);
        tick();
        imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_0BAD; flush = 1'b1; flush_pc = 32'h203;
        tick();
        imem_rvalid = 1'b0; flush = 1'b0;
        chk("fr_valid", {31'd0, instr_valid}, 32'd0);
        chk("fr_req", {31'd0, imem_req}, 32'd1);
        chk("fr_addr", imem_addr, 32'h200);

        // flush in REQ: old address still goes out, response is killed
        flush = 1'b1; flush_pc = 32'h300;
        chk("fq_req", {31'd0, imem_req}, 32'd1);
        chk("fq_addr_old", imem_addr, 32'h200);
        tick();
        flush = 1'b0;
        imem_rvalid = 1'b1; imem_rdata = 32'h1111_1111;
        tick();
        imem_rvalid = 1'b0;
        chk("fq_valid", {31'd0, instr_valid}, 32'd0);
        chk("fq_addr", imem_addr, 32'h300);

        // flush with instr_ready in HOLD: handshake does not count
        fetch("f300", 32'h300, 32'h0000_0017);
        flush = 1'b1; flush_pc = 32'h400;
        tick();
        flush = 1'b0;
        chk("fh_valid", {31'd0, instr_valid}, 32'd0);
        chk("fh_addr", imem_addr, 32'h400);

        // wrap: 0xFFFFFFFC + 4 = 0
        fetch("f400", 32'h400, 32'h0000_006F);
        flush = 1'b1; flush_pc = 32'hFFFF_FFFF;
        tick();
        flush = 1'b0;
        fetch("wrap", 32'hFFFF_FFFC, 32'h0000_0013);
        tick();
        chk("wrap_addr", imem_addr, 32'h0);

        // reset pulsed mid-WAIT
        fetch("f0b", 32'h0, 32'h0000_0013);
        tick();
        tick();
        n_rst = 1'b1;
        #1;
        chk("mr_req", {31'd0, imem_req}, 32'd0);
        chk("mr_valid", {31'd0, instr_valid}, 32'd0);
        chk("mr_addr", imem_addr, 32'h0);
        chk("mr_instr", instr, 32'h0);
        tick();
        n_rst = 1'b0;
        imem_rvalid = 1'b1; imem_rdata = 32'hCAFE_F00D;
        tick();
        imem_rvalid = 1'b0;
        chk("mr_req_after", {31'd0, imem_req}, 32'd1);
        chk("mr_addr_after", imem_addr, 32'h0);
        chk("mr_instr_after", instr, 32'h0);

        // flush in START
        n_rst = 1'b1;
        tick();
        n_rst = 1'b0;
        flush = 1'b1; flush_pc = 32'h501;
        tick();
        flush = 1'b0;
        fetch("f500", 32'h500, 32'hABCD_E0B7);
        tick();
        chk("f500_next", imem_addr, 32'h504);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
